// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO: read-mode encodings and depth derivation.
package sync_fifo_pkg;

    // Read-port modes selected by the FWFT parameter
    localparam int unsigned FWFT_REG  = 0;  // registered read, 1-cycle latency
    localparam int unsigned FWFT_FALL = 1;  // head entry presented while non-empty

    // Number of entries addressed by an asize-bit pointer
    function automatic int unsigned depth_of(input int unsigned asize);
        return 32'(1) << asize;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Synchronous FIFO handshake/status bundle.
//   master: drives clr, wdata, winc, rinc; observes rdata and all status.
//   slave : the FIFO itself.
interface sync_fifo_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 8
);
    logic             clr;
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wdata, winc, rinc,
        input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, wdata, winc, rinc,
        output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DSIZE x 2**ASIZE, one synchronous write port, one asynchronous read port.
// No reset on the array; contents survive reset and flush.
//   clk     : write clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata_c : combinational read data at raddr
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata_c
);
    localparam int unsigned DEPTH = depth_of(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_if.slave (clr, wdata, winc, rinc in; rdata, full, empty,
//           almost_full, almost_empty, count, overflow, underflow out)
// FWFT selects a registered read (1-cycle latency) or first-word-fall-through.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned ASIZE    = 8,
    parameter int unsigned AF_LEVEL = depth_of(ASIZE) - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = FWFT_REG
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = depth_of(ASIZE);
    localparam int unsigned CW    = ASIZE + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] rptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nx;
    logic             full_q;
    logic             empty_q;
    logic             af_q;
    logic             ae_q;
    logic             ovf_q;
    logic             unf_q;
    logic             wr_ok;
    logic             rd_ok;
    logic [DSIZE-1:0] mem_rdata;

    // Accept qualifiers use registered flags only; clr blocks both sides
    assign wr_ok = bus.winc && !full_q  && !bus.clr;
    assign rd_ok = bus.rinc && !empty_q && !bus.clr;

    // Next occupancy; flags are registered from it so they always match count
    always_comb begin
        count_nx = count_q;
        if (bus.clr) begin
            count_nx = '0;
        end else begin
            unique case ({wr_ok, rd_ok})
                2'b10:   count_nx = count_q + CW'(1);
                2'b01:   count_nx = count_q - CW'(1);
                default: count_nx = count_q;
            endcase
        end
    end

    // Pointers, occupancy and decoded flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            if (bus.clr) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_ok) wptr <= wptr + ASIZE'(1);
                if (rd_ok) rptr <= rptr + ASIZE'(1);
            end
            count_q <= count_nx;
            full_q  <= (count_nx == DEPTH_C);
            empty_q <= (count_nx == '0);
            af_q    <= (count_nx >= AF_C);
            ae_q    <= (count_nx <= AE_C);
        end
    end

    // Sticky error flags; a rejected request sets them, only clr/reset clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.winc && full_q)  ovf_q <= 1'b1;
            if (bus.rinc && empty_q) unf_q <= 1'b1;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .we      (wr_ok),
        .waddr   (wptr),
        .wdata   (bus.wdata),
        .raddr   (rptr),
        .rdata_c (mem_rdata)
    );

    // Read data path: head entry straight from storage, or a register loaded on accepted read
    generate
        if (FWFT == FWFT_FALL) begin : g_fwft
            assign bus.rdata = mem_rdata;
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (bus.clr) begin
                    rdata_q <= '0;
                end else if (rd_ok) begin
                    rdata_q <= mem_rdata;
                end
            end

            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: u0 in registered-read mode, u1 in first-word-fall-through mode.
// Read data of u0 is checked by a scoreboard: stimulus pushes the expected word
// for each read it expects to be accepted, a monitor pops and compares it one
// edge later. Flags and count are checked directly against hand-derived values.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic rd_tag;
    logic [7:0] exp_q [$];

    sync_fifo_if #(.DSIZE(8), .ASIZE(4)) b0 ();
    sync_fifo_if #(.DSIZE(8), .ASIZE(4)) b1 ();

    sync_fifo #(
        .DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(FWFT_REG)
    ) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    sync_fifo #(
        .DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(FWFT_FALL)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle0;
        b0.winc = 1'b0;
        b0.rinc = 1'b0;
        b0.clr  = 1'b0;
        rd_tag  = 1'b0;
    endtask

    task automatic idle1;
        b1.winc = 1'b0;
        b1.rinc = 1'b0;
        b1.clr  = 1'b0;
    endtask

    // Scoreboard monitor: an accepted read on u0 shows its data right after the edge
    initial begin
        forever begin
            @(posedge clk);
            if (rd_tag === 1'b1) begin
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underrun: got %0h expected none", b0.rdata);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (b0.rdata !== e) begin
                        failures++;
                        $display("FAIL sb_rdata: got %0h expected %0h at %0t", b0.rdata, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        b0.wdata = '0;
        b1.wdata = '0;
        idle0();
        idle1();

        // Reset state
        tick(); tick();
        chk("rst_count", 32'(b0.count), 0);
        chk("rst_empty", 32'(b0.empty), 1);
        chk("rst_ae",    32'(b0.almost_empty), 1);
        chk("rst_full",  32'(b0.full), 0);
        chk("rst_af",    32'(b0.almost_full), 0);
        chk("rst_ovf",   32'(b0.overflow), 0);
        chk("rst_unf",   32'(b0.underflow), 0);
        chk("rst_rdata", 32'(b0.rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_empty", 32'(b0.empty), 1);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            b0.winc  = 1'b1;
            b0.wdata = 8'(i);
            tick();
            chk("fill_count", 32'(b0.count), 32'(i + 1));
            chk("fill_af",    32'(b0.almost_full), 32'((i + 1) >= 14));
            chk("fill_ae",    32'(b0.almost_empty), 32'((i + 1) <= 2));
            chk("fill_full",  32'(b0.full), 32'(i == 15));
        end
        b0.wdata = 8'hFF;
        tick();
        idle0();
        chk("ovf_set",    32'(b0.overflow), 1);
        chk("ovf_count",  32'(b0.count), 16);
        chk("ovf_full",   32'(b0.full), 1);

        // Drain, expect 0x00..0x0F one edge after each rinc
        for (int i = 0; i < 16; i++) begin
            b0.rinc = 1'b1;
            rd_tag  = 1'b1;
            exp_q.push_back(8'(i));
            tick();
            chk("drain_count", 32'(b0.count), 32'(15 - i));
        end
        rd_tag = 1'b0;
        tick();
        idle0();
        chk("unf_set",   32'(b0.underflow), 1);
        chk("unf_rdata", 32'(b0.rdata), 32'h0F);
        chk("unf_empty", 32'(b0.empty), 1);
        chk("unf_count", 32'(b0.count), 0);

        // Flush clears sticky flags and the read register
        b0.clr = 1'b1;
        tick();
        idle0();
        chk("clr_ovf",   32'(b0.overflow), 0);
        chk("clr_unf",   32'(b0.underflow), 0);
        chk("clr_rdata", 32'(b0.rdata), 0);

        // Read on empty with a simultaneous write: write lands, read rejected
        b0.winc  = 1'b1;
        b0.rinc  = 1'b1;
        b0.wdata = 8'h33;
        tick();
        idle0();
        chk("ewr_count", 32'(b0.count), 1);
        chk("ewr_unf",   32'(b0.underflow), 1);
        chk("ewr_empty", 32'(b0.empty), 0);
        b0.rinc = 1'b1;
        rd_tag  = 1'b1;
        exp_q.push_back(8'h33);
        tick();
        idle0();
        b0.clr = 1'b1;
        tick();
        idle0();

        // Steady state at count=8 with pointer wrap
        for (int i = 0; i < 8; i++) begin
            b0.winc  = 1'b1;
            b0.wdata = 8'(8'h40 + i);
            tick();
        end
        idle0();
        chk("ss_pre_count", 32'(b0.count), 8);
        for (int k = 0; k < 40; k++) begin
            b0.winc  = 1'b1;
            b0.rinc  = 1'b1;
            b0.wdata = 8'(8'h48 + k);
            rd_tag   = 1'b1;
            exp_q.push_back(8'(8'h40 + k));
            tick();
            chk("ss_count", 32'(b0.count), 8);
        end
        idle0();
        for (int i = 0; i < 8; i++) begin
            b0.rinc = 1'b1;
            rd_tag  = 1'b1;
            exp_q.push_back(8'(8'h68 + i));
            tick();
        end
        idle0();
        chk("ss_empty", 32'(b0.empty), 1);

        // Full with simultaneous read and write: read only
        for (int i = 0; i < 16; i++) begin
            b0.winc  = 1'b1;
            b0.wdata = 8'(8'h80 + i);
            tick();
        end
        idle0();
        chk("fb_full", 32'(b0.full), 1);
        b0.winc  = 1'b1;
        b0.rinc  = 1'b1;
        b0.wdata = 8'hEE;
        rd_tag   = 1'b1;
        exp_q.push_back(8'h80);
        tick();
        idle0();
        chk("fb_count", 32'(b0.count), 15);
        chk("fb_ovf",   32'(b0.overflow), 1);
        chk("fb_full2", 32'(b0.full), 0);
        for (int i = 0; i < 15; i++) begin
            b0.rinc = 1'b1;
            rd_tag  = 1'b1;
            exp_q.push_back(8'(8'h81 + i));
            tick();
        end
        idle0();
        chk("fb_empty", 32'(b0.empty), 1);

        // Asynchronous reset mid-operation discards stored entries
        for (int i = 0; i < 3; i++) begin
            b0.winc  = 1'b1;
            b0.wdata = 8'(8'h10 + i);
            tick();
        end
        idle0();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(b0.count), 0);
        chk("arst_empty", 32'(b0.empty), 1);
        chk("arst_ovf",   32'(b0.overflow), 0);
        chk("arst_rdata", 32'(b0.rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        b0.winc  = 1'b1;
        b0.wdata = 8'h77;
        tick();
        idle0();
        chk("arst_wr_count", 32'(b0.count), 1);
        chk("arst_wr_mem",   32'(u0.u_mem.mem[0]), 32'h77);
        b0.rinc = 1'b1;
        rd_tag  = 1'b1;
        exp_q.push_back(8'h77);
        tick();
        idle0();

        // First-word-fall-through instance
        b1.winc  = 1'b1;
        b1.wdata = 8'hA5;
        tick();
        idle1();
        chk("fw_rdata",  32'(b1.rdata), 32'hA5);
        chk("fw_empty",  32'(b1.empty), 0);
        chk("fw_count",  32'(b1.count), 1);
        b1.winc  = 1'b1;
        b1.wdata = 8'h5A;
        tick();
        idle1();
        chk("fw_head",   32'(b1.rdata), 32'hA5);
        b1.rinc = 1'b1;
        tick();
        idle1();
        chk("fw_pop",    32'(b1.rdata), 32'h5A);
        chk("fw_pop_ct", 32'(b1.count), 1);
        b1.rinc = 1'b1;
        tick();
        b1.rinc = 1'b1;
        tick();
        idle1();
        chk("fw_unf",    32'(b1.underflow), 1);
        b1.winc  = 1'b1;
        b1.wdata = 8'hA5;
        tick();
        idle1();
        chk("fw_rd2",    32'(b1.rdata), 32'hA5);
        b1.clr = 1'b1;
        tick();
        idle1();
        chk("fw_clr_count", 32'(b1.count), 0);
        chk("fw_clr_empty", 32'(b1.empty), 1);
        chk("fw_clr_ovf",   32'(b1.overflow), 0);
        chk("fw_clr_unf",   32'(b1.underflow), 0);

        tick(); tick();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, data width in bits.
REQ-002 The block SHALL have parameter ASIZE, default 8, address width; DEPTH = 2**ASIZE entries.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in entries.
REQ-005 The block SHALL have parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 The block SHALL have port clr, input, 1, synchronous flush.
REQ-010 The block SHALL have port wdata, input, DSIZE, write data.
REQ-011 The block SHALL have port winc, input, 1, write request.
REQ-012 The block SHALL have port rinc, input, 1, read request.
REQ-013 The block SHALL have port rdata, output, DSIZE, read data.
REQ-014 The block SHALL have ports full and empty, output, 1 each, occupancy flags.
REQ-015 The block SHALL have ports almost_full and almost_empty, output, 1 each, threshold flags.
REQ-016 The block SHALL have port count, output, ASIZE+1, current occupancy, range 0..DEPTH.
REQ-017 The block SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-018 A write SHALL be accepted only when winc=1, full=0 and clr=0; wdata is stored at wptr and wptr increments by 1.
REQ-019 A read SHALL be accepted only when rinc=1, empty=0 and clr=0; rptr increments by 1.
REQ-020 wptr and rptr SHALL be ASIZE bits and wrap from DEPTH-1 to 0 without penalty.
REQ-021 count SHALL change by +1 on a write-only cycle, -1 on a read-only cycle, and 0 when both are accepted or neither is.
REQ-022 When full=1 and winc=1, the write SHALL be rejected even if a read is accepted in the same cycle; memory and wptr stay unchanged.
REQ-023 When empty=1 and rinc=1, the read SHALL be rejected even if a write is accepted in the same cycle; the write proceeds.
REQ-024 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).
REQ-025 almost_full SHALL equal (count>=AF_LEVEL) and almost_empty SHALL equal (count<=AE_LEVEL).
REQ-026 All flags and count SHALL be decoded from registered state only; there SHALL be no combinational path from any input to any output.
REQ-027 With FWFT=0, rdata SHALL be a register loaded with mem[rptr] on the edge that accepts a read; latency is 1 cycle, and rdata holds its value otherwise.
REQ-028 With FWFT=1, rdata SHALL present mem[rptr] whenever empty=0, and rinc SHALL act as the pop/acknowledge; rdata is don't-care while empty=1.
REQ-029 overflow SHALL set on any cycle with winc=1 and full=1, and underflow SHALL set on any cycle with rinc=1 and empty=1; both hold until clr or reset.
REQ-030 clr=1 SHALL, on the next edge, zero wptr, rptr, count, overflow, underflow and the FWFT=0 rdata register; clr overrides winc and rinc.
REQ-031 Memory contents SHALL NOT be cleared by clr or reset.

Reset
REQ-032 rst_n=0 SHALL immediately force wptr=0, rptr=0, count=0, rdata=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries; the first write after deassertion lands at address 0.
REQ-034 The memory array SHALL have no reset.

Structure
REQ-035 FWFT mode encodings and the DEPTH derivation SHALL live in shared package sync_fifo_pkg.
REQ-036 Storage SHALL be a separate sub-module sync_fifo_mem (DSIZE x DEPTH, one synchronous write port, one asynchronous read port); pointer, count and flag logic SHALL stay in sync_fifo.
REQ-037 The RTL SHALL be synthesisable for any ASIZE>=2, with 1<=AE_LEVEL<AF_LEVEL<=DEPTH-1.

Verification (DSIZE=8, ASIZE=4, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-038 Reset then idle -> empty=1, almost_empty=1, count=0, rdata=0, all other flags 0.
REQ-039 Write 0x00..0x0F in 16 consecutive cycles -> full=1 and count=16 after the 16th edge; almost_full=1 from count=14; a 17th winc sets overflow=1 and leaves count=16.
REQ-040 FWFT=0, drain 16 entries -> rdata sequence 0x00..0x0F, each one cycle after its rinc edge; a 17th rinc sets underflow=1 and leaves rdata=0x0F.
REQ-041 Run simultaneous winc/rinc at count=8 for 40 cycles -> count stays 8, pointers wrap, data stays in order.
REQ-042 At full with winc=rinc=1 -> one read accepted, write rejected, count=15, overflow=1.
REQ-043 FWFT=1, write 0xA5 into empty FIFO -> rdata=0xA5 and empty=0 one edge later with no rinc; then clr -> count=0, empty=1, overflow=underflow=0.
